// File: rtl/bpsk_modulator.sv
// BPSK modulator: serial bits -> signed sine-carrier samples, bit 1 = 180 deg phase flip.
// Latency: one cycle from an accept edge to index 0 of the symbol; all outputs registered.
// Backpressure: a bit is taken only when enabled and idle or at the last sample; upstream is paced by next.
module bpsk_modulator #(
    parameter int SAMPLE_W       = 8,
    parameter int PHASE_STEPS    = 16,
    parameter int CYCLES_PER_BIT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       next,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    output logic                       symbol_start,
    output logic                       underrun
);

    localparam int N     = PHASE_STEPS * CYCLES_PER_BIT;
    localparam int IDX_W = $clog2(N);
    localparam int PH_W  = $clog2(PHASE_STEPS);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam real PI = 3.14159265358979323846;

    // Elaboration-time sine entry, rounded half away from zero so the table is symmetric.
    function automatic logic signed [SAMPLE_W-1:0] sine_entry(input int k);
        real amp;
        real r;
        int  v;
        amp = real'((2 ** (SAMPLE_W - 1)) - 1);
        r   = amp * $sin(2.0 * PI * real'(k) / real'(PHASE_STEPS));
        if (r >= 0.0) begin
            v = $rtoi(r + 0.5);
        end else begin
            v = -$rtoi(0.5 - r);
        end
        return SAMPLE_W'(v);
    endfunction

    logic signed [SAMPLE_W-1:0] lut [PHASE_STEPS];

    for (genvar k = 0; k < PHASE_STEPS; k++) begin : g_lut
        localparam logic signed [SAMPLE_W-1:0] ENTRY = sine_entry(k);
        assign lut[k] = ENTRY;
    end

    logic [0:0]                 state;
    logic [IDX_W-1:0]           idx;
    logic                       bit_lat;

    logic                       accept;
    logic [IDX_W-1:0]           idx_nxt;
    logic signed [SAMPLE_W-1:0] lut_nxt;

    // Accept decision and the table entry for the following sample index.
    always_comb begin
        accept  = enable && bit_valid && ((state == S_IDLE) || (idx == LAST));
        idx_nxt = idx + IDX_W'(1);
        lut_nxt = lut[idx_nxt[PH_W-1:0]];
    end

    // Symbol sequencing: start/chain symbols on accept, stream samples, fall idle at symbol end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            bit_lat      <= 1'b0;
            next         <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            symbol_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            next         <= 1'b0;
            symbol_start <= 1'b0;
            underrun     <= 1'b0;
            if (accept) begin
                bit_lat      <= bit_in;
                state        <= S_RUN;
                idx          <= '0;
                next         <= 1'b1;
                symbol_start <= 1'b1;
                sample_valid <= 1'b1;
                sample_out   <= bit_in ? -lut[0] : lut[0];
            end else if (state == S_RUN) begin
                if (idx == LAST) begin
                    // Stream ends here; only a starved-but-enabled sender counts as underrun.
                    state        <= S_IDLE;
                    idx          <= '0;
                    sample_out   <= '0;
                    sample_valid <= 1'b0;
                    underrun     <= enable && !bit_valid;
                end else begin
                    idx        <= idx_nxt;
                    sample_out <= bit_lat ? -lut_nxt : lut_nxt;
                end
            end else begin
                sample_out   <= '0;
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bpsk_modulator.sv
// Directed bench for bpsk_modulator with a sample scoreboard.
// Stimulus pushes the expected 64 samples of each issued bit; a monitor pops on sample_valid.
// Test sequences check next/underrun pulses and idle/reset outputs directly.
module tb_bpsk_modulator;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              bit_in;
    logic              bit_valid;
    logic              next;
    logic signed [7:0] sample_out;
    logic              sample_valid;
    logic              symbol_start;
    logic              underrun;

    typedef struct {
        int s;
        int st;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int nxt_cnt     = 0;
    int urun_cnt    = 0;

    // Hand-computed 127*sin(2*pi*k/16), rounded.
    int sin_tab [16] = '{0, 49, 90, 117, 127, 117, 90, 49,
                         0, -49, -90, -117, -127, -117, -90, -49};

    bpsk_modulator #(
        .SAMPLE_W      (8),
        .PHASE_STEPS   (16),
        .CYCLES_PER_BIT(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .next        (next),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .symbol_start(symbol_start),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop expected samples while valid; outputs must be quiet otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (next === 1'b1) nxt_cnt++;
        if (underrun === 1'b1) urun_cnt++;
        if (rst_n === 1'b1 || sample_valid === 1'b1) begin
            if (sample_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample_out", int'(sample_out), e.s);
                    chk("symbol_start", int'(symbol_start), e.st);
                    chk("next_with_start", int'(next), e.st);
                end
            end else begin
                chk("idle_sample_out", int'(sample_out), 0);
                chk("idle_symbol_start", int'(symbol_start), 0);
            end
        end
    end

    // Issue one bit: queue its 64 expected samples, present it, wait for the next pulse.
    task automatic send_bit(input bit b, output int waited);
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            e.s  = b ? -sin_tab[i % 16] : sin_tab[i % 16];
            e.st = (i == 0) ? 1 : 0;
            exp_q.push_back(e);
        end
        bit_in    = b;
        bit_valid = 1'b1;
        enable    = 1'b1;
        waited    = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (next !== 1'b1 && waited < 200);
        if (next !== 1'b1) chk("next_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sample_valid !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sample_valid !== 1'b0) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int u0;
        int n0;

        // Reset held with a valid bit offered: nothing may come out.
        rst_n     = 1'b0;
        enable    = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_next", int'(next), 0);
            chk("rst_sample_out", int'(sample_out), 0);
            chk("rst_sample_valid", int'(sample_valid), 0);
            chk("rst_symbol_start", int'(symbol_start), 0);
            chk("rst_underrun", int'(underrun), 0);
        end
        bit_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("post_rst_no_next", nxt_cnt, 0);

        // Single bit 0 then starve: 64 samples, idle, one underrun pulse.
        send_bit(1'b0, w);
        chk("first_accept_latency", w, 1);
        bit_valid = 1'b0;
        wait_idle();
        chk("single_underrun", int'(underrun), 1);
        chk("single_idle_out", int'(sample_out), 0);
        chk("single_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("single_underrun_1cyc", int'(underrun), 0);
        chk("single_urun_cnt", urun_cnt, 1);

        // Bits 0 then 1 back to back: seamless, next 64 cycles apart, then stop cleanly.
        u0 = urun_cnt;
        n0 = nxt_cnt;
        send_bit(1'b0, w);
        send_bit(1'b1, w);
        chk("b2b_next_spacing", w, 64);
        bit_valid = 1'b0;
        enable    = 1'b0;
        wait_idle();
        chk("b2b_queue_empty", exp_q.size(), 0);
        chk("b2b_no_underrun", urun_cnt, u0);
        chk("b2b_next_count", nxt_cnt - n0, 2);

        // Enable dropped at s[20] with a bit still offered: symbol completes, nothing more.
        u0 = urun_cnt;
        n0 = nxt_cnt;
        send_bit(1'b0, w);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("en_drop_queue_empty", exp_q.size(), 0);
        chk("en_drop_no_underrun", urun_cnt, u0);
        chk("en_drop_next_count", nxt_cnt - n0, 1);
        chk("en_drop_stays_idle", int'(sample_valid), 0);
        bit_valid = 1'b0;

        // Reset at s[30]: outputs clear next cycle, then a fresh symbol starts at phase 0.
        send_bit(1'b1, w);
        repeat (30) @(negedge clk);
        rst_n     = 1'b0;
        bit_valid = 1'b1;
        @(negedge clk);
        chk("midrst_sample_valid", int'(sample_valid), 0);
        chk("midrst_sample_out", int'(sample_out), 0);
        chk("midrst_next", int'(next), 0);
        chk("midrst_queue_left", exp_q.size(), 33);
        exp_q.delete();
        bit_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        n0 = nxt_cnt;
        send_bit(1'b0, w);
        chk("midrst_restart_latency", w, 1);
        bit_valid = 1'b0;
        enable    = 1'b0;
        wait_idle();
        chk("midrst_next_once", nxt_cnt - n0, 1);

        // Underrun, then bit_valid raised 5 cycles later: restart at phase 0 on the next edge.
        send_bit(1'b0, w);
        bit_valid = 1'b0;
        wait_idle();
        chk("late_underrun", int'(underrun), 1);
        repeat (4) @(negedge clk);
        send_bit(1'b1, w);
        chk("late_restart_latency", w, 1);
        bit_valid = 1'b0;
        enable    = 1'b0;
        wait_idle();
        chk("late_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
